seg7_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for a common-cathode multi-digit 7-segment display on the board wrapper. It shares the one segment bus (a–g, dp) between DIGITS digit enables, inserting dead time between digits so no digit shows ghost segments. It latches new display values only at frame boundaries and optionally dims the display with a per-slot PWM. It replaces free-running counter-bit digit selection in the wrapper; the core's output byte feeds `value`.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
// Holds the slot phase enum, the hex-to-segment table and the blank pattern.
package seg7_pkg;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } phase_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment patterns {a,b,c,d,e,f,g}, active-high; entry 0 is the rightmost
  // item of the list, so the list runs from F down to 0.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b1000111,
    7'b1001111,
    7'b0111101,
    7'b1001110,
    7'b0011111,
    7'b1110111,
    7'b1111011,
    7'b1111111,
    7'b1110000,
    7'b1011111,
    7'b1011011,
    7'b0110011,
    7'b1111001,
    7'b1101101,
    7'b0110000,
    7'b1111110
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to 7-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; every nibble value has a defined glyph
  always_comb begin
    seg_o = HEX_SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan scheduler for a common-cathode
// multi-digit 7-segment display. Each digit gets a slot of SLOT_CYCLES clocks,
// the first DEAD_CYCLES of which are blanked so the segment bus can settle.
// New values are staged in a pending buffer and promoted at frame boundaries.
// Optional per-slot PWM dimming is enabled by defining SEG7_BRIGHTNESS_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int SLOT_CYCLES = 64,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     en,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST      = DIG_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  phase_e              phase_q, phase_d;

  logic [4*DIGITS-1:0] pendVal_q, pendVal_d;
  logic [DIGITS-1:0]   pendDp_q, pendDp_d;
  logic                pendFlag_q, pendFlag_d;
  logic [4*DIGITS-1:0] actVal_q, actVal_d;
  logic [DIGITS-1:0]   actDp_q, actDp_d;

  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                frameDone_q, frameDone_d;

  logic                frameEdge;
  logic [3:0]          actNibble;
  logic                actDpBit;
  logic [6:0]          decSeg;
  logic                pwmOn;

  // The last clock of the last digit's slot is the step into slot 0 DEAD
  assign frameEdge = (cnt_q == CNT_LAST) && (dig_q == DIG_LAST);

  // Slot counter, digit index and DEAD/ON phase advance on every clock
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    dig_d   = dig_q;
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = PH_DEAD;
      dig_d   = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end else if (cnt_q == CNT_DEAD_LAST) begin
      phase_d = PH_ON;
    end
  end

  // Loads stage into the pending buffer, promoted only on the frame step;
  // a load landing exactly on that step bypasses staging entirely
  always_comb begin
    pendVal_d  = pendVal_q;
    pendDp_d   = pendDp_q;
    pendFlag_d = pendFlag_q;
    actVal_d   = actVal_q;
    actDp_d    = actDp_q;
    if (frameEdge) begin
      pendFlag_d = 1'b0;
      if (load) begin
        actVal_d = value;
        actDp_d  = dp_in;
      end else if (pendFlag_q) begin
        actVal_d = pendVal_q;
        actDp_d  = pendDp_q;
      end
    end else if (load) begin
      pendVal_d  = value;
      pendDp_d   = dp_in;
      pendFlag_d = 1'b1;
    end
  end

  // Pick the active nibble and decimal point of the digit being scanned
  always_comb begin
    actNibble = 4'h0;
    actDpBit  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q == DIG_W'(k)) begin
        actNibble = actVal_q[4*k +: 4];
        actDpBit  = actDp_q[k];
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble_i (actNibble),
    .seg_o    (decSeg)
  );

`ifdef SEG7_BRIGHTNESS_EN
  // Dimming: within each 16-clock window only the first bright+1 clocks light
  always_comb begin
    pwmOn = (cnt_q[3:0] <= bright);
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;

  // Without dimming the digit stays lit for its whole ON phase
  always_comb begin
    pwmOn = 1'b1;
  end
`endif

  // Output next-state: segments change only on the first DEAD clock, so
  // they are always stable while any enable is high
  always_comb begin
    seg_d       = seg_q;
    dp_d        = dp_q;
    en_d        = '0;
    frameDone_d = frameEdge;
    if (cnt_q == '0) begin
      seg_d = decSeg;
      dp_d  = actDpBit;
    end
    for (int k = 0; k < DIGITS; k++) begin
      en_d[k] = (phase_q == PH_ON) && !blank && pwmOn && (dig_q == DIG_W'(k));
    end
  end

  // Scan position and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      phase_q <= PH_DEAD;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      phase_q <= phase_d;
    end
  end

  // Pending and active display buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendVal_q  <= '0;
      pendDp_q   <= '0;
      pendFlag_q <= 1'b0;
      actVal_q   <= '0;
      actDp_q    <= '0;
    end else begin
      pendVal_q  <= pendVal_d;
      pendDp_q   <= pendDp_d;
      pendFlag_q <= pendFlag_d;
      actVal_q   <= actVal_d;
      actDp_q    <= actDp_d;
    end
  end

  // Registered display outputs, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b0;
      en_q        <= '0;
      frameDone_q <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      en_q        <= en_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign en         = en_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl with
// default parameters (2 digits, 64-clock slots, 4 dead clocks).
module tb_seg7_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] SA = 7'b1110111;

  logic       clk;
  logic       rst_n;
  logic [7:0] value;
  logic [1:0] dp_in;
  logic       load;
  logic       blank;
  logic [3:0] bright;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] en;
  logic       frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  seg7_scan_ctrl #(
    .DIGITS      (2),
    .SLOT_CYCLES (64),
    .DEAD_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .bright     (bright),
    .seg        (seg),
    .dp         (dp),
    .en         (en),
    .frame_done (frame_done)
  );

  // Free-running 100 MHz-style clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; cyc numbers edges since reset release
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected enables after edge c, from the slot timing and the blank/bright
  // values presented before that edge
  function automatic logic [1:0] exp_en(int c);
    int   slotPos;
    int   digit;
    logic pwm;
    slotPos = (c - 1) % 64;
    digit   = ((c - 1) / 64) % 2;
    pwm     = 1'b1;
`ifdef SEG7_BRIGHTNESS_EN
    pwm = ((slotPos % 16) <= int'(bright));
`endif
    if (slotPos < 4 || blank || !pwm) return 2'b00;
    return (digit == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic test_reset();
    rst_n  = 1'b1;
    value  = 8'h00;
    dp_in  = 2'b00;
    load   = 1'b0;
    blank  = 1'b0;
    bright = 4'hF;
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if ({en, frame_done, dp, seg} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got en=%b fd=%b dp=%b seg=%b expected all zero",
               en, frame_done, dp, seg);
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_first_frame();
    logic [1:0] e;
    logic [6:0] eSeg;
    logic       eDp;
    for (int k = 1; k <= 256; k++) begin
      load = (k == 2);
      if (k == 2) begin
        value = 8'h3A;
        dp_in = 2'b01;
      end
      e = exp_en(k);
      tick();
      if (k <= 128) begin
        eSeg = S0;
        eDp  = 1'b0;
      end else if (((k - 1) / 64) % 2 == 0) begin
        eSeg = SA;
        eDp  = 1'b1;
      end else begin
        eSeg = S3;
        eDp  = 1'b0;
      end
      vectors++;
      if ({en, frame_done, dp, seg} !== {e, (k % 128 == 0), eDp, eSeg}) begin
        miscompares++;
        $display("[TB] FAIL first_frame cyc=%0d got en=%b fd=%b dp=%b seg=%b expected en=%b fd=%b dp=%b seg=%b",
                 cyc, en, frame_done, dp, seg, e, (k % 128 == 0), eDp, eSeg);
      end
    end
  endtask

  task automatic test_last_wins();
    logic [1:0] e;
    logic [6:0] eSeg;
    logic       eDp;
    for (int k = 257; k <= 511; k++) begin
      load = (k == 290) || (k == 300);
      if (k == 290) begin
        value = 8'h12;
        dp_in = 2'b10;
      end
      if (k == 300) begin
        value = 8'h34;
        dp_in = 2'b00;
      end
      e = exp_en(k);
      tick();
      if (((k - 1) / 64) % 2 == 1) begin
        eSeg = S3;
        eDp  = 1'b0;
      end else if (k <= 384) begin
        eSeg = SA;
        eDp  = 1'b1;
      end else begin
        eSeg = S4;
        eDp  = 1'b0;
      end
      vectors++;
      if ({en, frame_done, dp, seg} !== {e, (k % 128 == 0), eDp, eSeg}) begin
        miscompares++;
        $display("[TB] FAIL last_wins cyc=%0d got en=%b fd=%b dp=%b seg=%b expected en=%b fd=%b dp=%b seg=%b",
                 cyc, en, frame_done, dp, seg, e, (k % 128 == 0), eDp, eSeg);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [1:0] e;
    logic [6:0] eSeg;
    logic       eDp;
    for (int k = 512; k <= 599; k++) begin
      load = (k == 512);
      if (k == 512) begin
        value = 8'h56;
        dp_in = 2'b11;
      end
      e = exp_en(k);
      tick();
      if (k == 512) begin
        eSeg = S3;
        eDp  = 1'b0;
      end else begin
        eSeg = (((k - 1) / 64) % 2 == 0) ? S6 : S5;
        eDp  = 1'b1;
      end
      vectors++;
      if ({en, frame_done, dp, seg} !== {e, (k % 128 == 0), eDp, eSeg}) begin
        miscompares++;
        $display("[TB] FAIL boundary_load cyc=%0d got en=%b fd=%b dp=%b seg=%b expected en=%b fd=%b dp=%b seg=%b",
                 cyc, en, frame_done, dp, seg, e, (k % 128 == 0), eDp, eSeg);
      end
    end
  endtask

  task automatic test_blank();
    logic [1:0] e;
    logic [6:0] eSeg;
    for (int k = 600; k <= 840; k++) begin
      load  = 1'b0;
      blank = (k >= 601) && (k <= 800);
      e = exp_en(k);
      tick();
      eSeg = (((k - 1) / 64) % 2 == 0) ? S6 : S5;
      vectors++;
      if ({en, frame_done, dp, seg} !== {e, (k % 128 == 0), 1'b1, eSeg}) begin
        miscompares++;
        $display("[TB] FAIL blank cyc=%0d got en=%b fd=%b dp=%b seg=%b expected en=%b fd=%b dp=1 seg=%b",
                 cyc, en, frame_done, dp, seg, e, (k % 128 == 0), eSeg);
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_brightness();
    logic [1:0] e;
    logic [6:0] eSeg;
    int         litCount;
    int         expLit;
`ifdef SEG7_BRIGHTNESS_EN
    bright = 4'd3;
    expLit = 12;
`else
    bright = 4'd0;
    expLit = 60;
`endif
    litCount = 0;
    for (int k = 841; k <= 968; k++) begin
      e = exp_en(k);
      tick();
      if (k >= 897 && k <= 960 && en[0]) litCount++;
      eSeg = (((k - 1) / 64) % 2 == 0) ? S6 : S5;
      vectors++;
      if ({en, frame_done, dp, seg} !== {e, (k % 128 == 0), 1'b1, eSeg}) begin
        miscompares++;
        $display("[TB] FAIL brightness cyc=%0d got en=%b fd=%b dp=%b seg=%b expected en=%b fd=%b dp=1 seg=%b",
                 cyc, en, frame_done, dp, seg, e, (k % 128 == 0), eSeg);
      end
    end
    vectors++;
    if (litCount !== expLit) begin
      miscompares++;
      $display("[TB] FAIL brightness_lit_count got %0d cycles lit, expected %0d", litCount, expLit);
    end
    bright = 4'hF;
  endtask

  task automatic test_async_reset();
    logic [1:0] e;
    logic [6:0] eSeg;
    for (int k = 969; k <= 980; k++) begin
      e = exp_en(k);
      tick();
      eSeg = (((k - 1) / 64) % 2 == 0) ? S6 : S5;
      vectors++;
      if ({en, frame_done, dp, seg} !== {e, (k % 128 == 0), 1'b1, eSeg}) begin
        miscompares++;
        $display("[TB] FAIL pre_reset cyc=%0d got en=%b fd=%b dp=%b seg=%b expected en=%b fd=%b dp=1 seg=%b",
                 cyc, en, frame_done, dp, seg, e, (k % 128 == 0), eSeg);
      end
    end
    vectors++;
    if (en !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL digit1_on_before_reset got en=%b expected 10", en);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({en, frame_done, dp, seg} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL async_clear got en=%b fd=%b dp=%b seg=%b expected all zero before any edge",
               en, frame_done, dp, seg);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({en, frame_done, dp, seg} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_held got en=%b fd=%b dp=%b seg=%b expected all zero",
               en, frame_done, dp, seg);
    end
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 70; k++) begin
      e = exp_en(k);
      tick();
      vectors++;
      if ({en, frame_done, dp, seg} !== {e, 1'b0, 1'b0, S0}) begin
        miscompares++;
        $display("[TB] FAIL restart cyc=%0d got en=%b fd=%b dp=%b seg=%b expected en=%b fd=0 dp=0 seg=%b",
                 cyc, en, frame_done, dp, seg, e, S0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_last_wins();
    test_boundary_load();
    test_blank();
    test_brightness();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
